// File: rtl/alarm_controller_if.sv
// Keypad/button inputs and display/register strobes of the alarm controller.
interface alarm_controller_if;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       show_alarm;
  logic       show_new_time;
  logic       shift;
  logic       load_new_a;
  logic       load_new_c;

  modport master (
    output one_second, key, alarm_button, time_button,
    input  show_alarm, show_new_time, shift,
    input  load_new_a, load_new_c
  );

  modport slave (
    input  one_second, key, alarm_button, time_button,
    output show_alarm, show_new_time, shift,
    output load_new_a, load_new_c
  );
endinterface

// File: rtl/alarm_controller.sv
// Keypad sequencing FSM for the alarm clock.
// Define KEY_TIMEOUT_EN to build the 1 Hz key-entry timeout.
module alarm_controller #(
  parameter int TIMEOUT_SEC = 10,
  parameter int CNT_W       = 4
) (
  input  logic              clock,
  input  logic              reset,
  alarm_controller_if.slave bus
);

  typedef enum logic [2:0] {
    SHOW_TIME,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY,
    SHOW_ALARM
  } state_t;

  state_t state;
  logic   load_a;
  logic   load_c;
  logic   digit;
  logic   timeout;

  assign digit = (bus.key <= 4'd9);

`ifdef KEY_TIMEOUT_EN
  logic [CNT_W-1:0] count;
  logic             counting;

  assign counting = (state == KEY_WAITED) || (state == KEY_ENTRY);
  assign timeout  = (count == CNT_W'(TIMEOUT_SEC));

  // Saturates at the limit so a long idle never wraps back to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!counting) begin
      count <= '0;
    end else if (bus.one_second && !timeout) begin
      count <= count + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;

  assign timeout    = 1'b0;
  assign unused_cnt = CNT_W'(TIMEOUT_SEC) ^ {CNT_W{bus.one_second}};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= SHOW_TIME;
      load_a <= 1'b0;
      load_c <= 1'b0;
    end else begin
      load_a <= 1'b0;
      load_c <= 1'b0;
      unique case (state)
        SHOW_TIME: begin
          if (bus.alarm_button) state <= SHOW_ALARM;
          else if (digit)       state <= KEY_STORED;
        end
        KEY_STORED: state <= KEY_WAITED;
        KEY_WAITED: begin
          if (!digit)       state <= KEY_ENTRY;
          else if (timeout) state <= SHOW_TIME;
        end
        KEY_ENTRY: begin
          if (bus.alarm_button) begin
            state  <= SHOW_TIME;
            load_a <= 1'b1;
          end else if (bus.time_button) begin
            state  <= SHOW_TIME;
            load_c <= 1'b1;
          end else if (digit) begin
            state <= KEY_STORED;
          end else if (timeout) begin
            state <= SHOW_TIME;
          end
        end
        SHOW_ALARM: begin
          if (!bus.alarm_button) state <= SHOW_TIME;
        end
        default: state <= SHOW_TIME;
      endcase
    end
  end

  assign bus.show_alarm    = (state == SHOW_ALARM);
  assign bus.show_new_time = (state == KEY_STORED) ||
                             (state == KEY_WAITED) ||
                             (state == KEY_ENTRY);
  assign bus.shift         = (state == KEY_STORED);
  assign bus.load_new_a    = load_a;
  assign bus.load_new_c    = load_c;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller against a mode-level reference model.
module tb_alarm_controller;
  localparam int T = 10;
`ifdef KEY_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;

  alarm_controller_if bus();

  alarm_controller #(.TIMEOUT_SEC(T), .CNT_W(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model: mode 0 = clock shown, 1 = alarm shown, 2 = digit entry.
  int mode;
  bit fresh;
  bit held;
  bit la;
  bit lc;
  int secs;

  function automatic logic [4:0] obs();
    return {bus.show_alarm, bus.show_new_time, bus.shift,
            bus.load_new_a, bus.load_new_c};
  endfunction

  function automatic logic [4:0] expv();
    return {mode == 1, mode == 2, fresh, la, lc};
  endfunction

  task automatic model_reset();
    mode  = 0;
    fresh = 0;
    held  = 0;
    la    = 0;
    lc    = 0;
    secs  = 0;
  endtask

  task automatic model_edge();
    bit dig;
    bit to;
    bit counting;
    dig      = (bus.key <= 4'd9);
    to       = TO_EN && (secs == T);
    counting = (mode == 2) && !fresh;
    la = 0;
    lc = 0;
    if (reset) begin
      model_reset();
      return;
    end
    case (mode)
      1: if (!bus.alarm_button) mode = 0;
      0: begin
        if (bus.alarm_button) mode = 1;
        else if (dig) begin
          mode  = 2;
          fresh = 1;
          held  = 1;
        end
      end
      default: begin
        if (fresh) fresh = 0;
        else if (held) begin
          if (!dig) held = 0;
          else if (to) mode = 0;
        end else if (bus.alarm_button) begin
          mode = 0;
          la   = 1;
        end else if (bus.time_button) begin
          mode = 0;
          lc   = 1;
        end else if (dig) begin
          fresh = 1;
          held  = 1;
        end else if (to) mode = 0;
      end
    endcase
    if (!counting) secs = 0;
    else if (bus.one_second && secs < T) secs = secs + 1;
  endtask

  task automatic set(input int k, input bit ab, input bit tb,
                     input bit tick);
    bus.key          = 4'(k);
    bus.alarm_button = ab;
    bus.time_button  = tb;
    bus.one_second   = tick;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic test_reset();
    total++;
    if (obs() !== 5'b0) begin
      bad++;
      $display("FAIL reset_init got=%b want=%b", obs(), 5'b0);
    end
    set(3, 0, 0, 0);
    step();
    step();
    #2 reset = 1'b1;
    #1;
    model_reset();
    total++;
    if (obs() !== 5'b0) begin
      bad++;
      $display("FAIL reset_async got=%b want=%b", obs(), 5'b0);
    end
    @(negedge clock);
    set(15, 0, 0, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs() !== expv() || bus.show_new_time !== 1'b0) begin
        bad++;
        $display("FAIL reset_release got=%b want=%b", obs(), expv());
      end
    end
  endtask

  task automatic test_digit_entry();
    int shifts = 0;
    int plan[4][2] = '{'{2, 5}, '{15, 1}, '{7, 3}, '{12, 2}};
    for (int p = 0; p < 4; p++) begin
      set(plan[p][0], 0, 0, 0);
      for (int i = 0; i < plan[p][1]; i++) begin
        step();
        shifts += int'(bus.shift);
        total++;
        if (obs() !== expv()) begin
          bad++;
          $display("FAIL digit_entry got=%b want=%b", obs(), expv());
        end
      end
    end
    total++;
    if (shifts != 2) begin
      bad++;
      $display("FAIL digit_shift_count got=%0d want=2", shifts);
    end
  endtask

  task automatic test_commit_time();
    int nc = 0;
    int na = 0;
    set(15, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      set(15, 0, 0, 0);
      nc += int'(bus.load_new_c);
      na += int'(bus.load_new_a);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL commit_time got=%b want=%b", obs(), expv());
      end
    end
    total++;
    if (nc != 1 || na != 0 || bus.show_new_time !== 1'b0) begin
      bad++;
      $display("FAIL commit_pulses got=c%0d/a%0d want=c1/a0", nc, na);
    end
  endtask

  task automatic test_button_priority();
    int na = 0;
    int nc = 0;
    int sh = 0;
    set(8, 0, 0, 0);
    step();
    step();
    set(15, 0, 0, 0);
    step();
    step();
    set(5, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      set(15, 0, 0, 0);
      na += int'(bus.load_new_a);
      nc += int'(bus.load_new_c);
      sh += int'(bus.shift);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL button_priority got=%b want=%b", obs(), expv());
      end
    end
    total++;
    if (na != 1 || nc != 0 || sh != 0) begin
      bad++;
      $display("FAIL priority_pulses got=a%0d/c%0d/s%0d want=a1/c0/s0",
               na, nc, sh);
    end
  endtask

  task automatic test_timeout();
    set(6, 0, 0, 0);
    step();
    step();
    set(15, 0, 0, 0);
    step();
    for (int i = 0; i < 2 * T + 2; i++) begin
      set(15, 0, 0, (i % 2 == 0) && (i < 2 * T));
      step();
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL timeout_run got=%b want=%b", obs(), expv());
      end
    end
    total++;
    if (bus.show_new_time !== !TO_EN || bus.load_new_a || bus.load_new_c) begin
      bad++;
      $display("FAIL timeout_exit got=%b want=%b", bus.show_new_time, !TO_EN);
    end
    #2 reset = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    set(1, 0, 0, 0);
    step();
    step();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < T - 1; i++) begin
        set(15, 0, 0, 1);
        step();
        set(15, 0, 0, 0);
        step();
      end
      set(4, 0, 0, 1);
      step();
      step();
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL timeout_clear got=%b want=%b", obs(), expv());
      end
    end
    total++;
    if (bus.show_new_time !== 1'b1) begin
      bad++;
      $display("FAIL timeout_no_exit got=%b want=1", bus.show_new_time);
    end
    #2 reset = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    set(15, 0, 0, 0);
  endtask

  task automatic test_show_alarm();
    int sh = 0;
    for (int i = 0; i < 20; i++) begin
      set(i % 10, 1, i % 3 == 0, 0);
      step();
      sh += int'(bus.shift);
      total++;
      if (obs() !== expv() || (i > 0 && bus.show_alarm !== 1'b1)) begin
        bad++;
        $display("FAIL show_alarm got=%b want=%b", obs(), expv());
      end
    end
    set(15, 0, 0, 0);
    step();
    total++;
    if (sh != 0 || bus.show_alarm !== 1'b0) begin
      bad++;
      $display("FAIL alarm_release got=sa%b/s%0d want=sa0/s0",
               bus.show_alarm, sh);
    end
  endtask

  task automatic test_random();
    int k = 15;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0)
        k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 9))
                                        : int'($urandom_range(10, 15));
      set(k, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 2) == 0);
      step();
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL random i=%0d got=%b want=%b", i, obs(), expv());
      end
    end
  endtask

  initial begin
    set(15, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_digit_entry();
    test_commit_time();
    test_button_priority();
    test_timeout();
    test_show_alarm();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
